// File: rtl/rf_pkg.sv
// Shared constants and helpers for the rename register file.
package rf_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int NUM_ARCH_REGS = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // x0 is hardwired: it is never renamed, never written and always reads zero.
    function automatic logic is_zero_reg(input reg_addr_t addr);
        return (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/rename_register_file_if.sv
// Bus between the register file, the instruction unit and the reorder buffer.
//
// Handshake semantics: every *ValidIn is a single-cycle qualifier sampled on
// the rising clock edge. There is no ready/backpressure signal; the register
// file accepts every valid rename and commit in the cycle it is presented and
// never stalls. Read ports have no valid at all: the address is latched every
// edge and results appear combinationally in the following cycle.
interface rename_register_file_if
    import rf_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int XLEN      = 32,
    parameter int NUM_READ  = 2
);

    // Operand read (instruction unit side)
    logic [NUM_READ*REG_ADDR_W-1:0] rdAddrIn;
    logic [NUM_READ-1:0]            rdDirtyOut;
    logic [NUM_READ*ROB_WIDTH-1:0]  rdDepOut;
    logic [NUM_READ*XLEN-1:0]       rdValueOut;

    // Operand ready lookup (reorder buffer side)
    logic [NUM_READ*ROB_WIDTH-1:0]  robDepOut;
    logic [NUM_READ-1:0]            robReadyIn;
    logic [NUM_READ*XLEN-1:0]       robValueIn;

    // Rename (instruction unit side)
    logic                           renameValidIn;
    reg_addr_t                      renameDestIn;
    logic [ROB_WIDTH-1:0]           renameRobIdIn;

    // Commit and flush (reorder buffer side)
    logic                           commitValidIn;
    reg_addr_t                      commitDestIn;
    logic [ROB_WIDTH-1:0]           commitRobIdIn;
    logic [XLEN-1:0]                commitValueIn;
    logic                           flushIn;

    // Driven by the instruction unit / reorder buffer (or a testbench).
    modport master (
        output rdAddrIn,
        output robReadyIn,
        output robValueIn,
        output renameValidIn,
        output renameDestIn,
        output renameRobIdIn,
        output commitValidIn,
        output commitDestIn,
        output commitRobIdIn,
        output commitValueIn,
        output flushIn,
        input  rdDirtyOut,
        input  rdDepOut,
        input  rdValueOut,
        input  robDepOut
    );

    // The register file itself.
    modport slave (
        input  rdAddrIn,
        input  robReadyIn,
        input  robValueIn,
        input  renameValidIn,
        input  renameDestIn,
        input  renameRobIdIn,
        input  commitValidIn,
        input  commitDestIn,
        input  commitRobIdIn,
        input  commitValueIn,
        input  flushIn,
        output rdDirtyOut,
        output rdDepOut,
        output rdValueOut,
        output robDepOut
    );

endinterface

// File: rtl/rf_read_port.sv
// One operand read port: latches the address each edge, then resolves the
// operand from the current register/busy/tag state, the ROB ready lookup and
// a same-cycle commit of the producing instruction.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int XLEN      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  reg_addr_t            addr_i,
    input  logic [NUM_ARCH_REGS-1:0] busy_i,
    input  logic [ROB_WIDTH-1:0] tag_i [NUM_ARCH_REGS],
    input  logic [XLEN-1:0]      reg_i [NUM_ARCH_REGS],
    input  logic                 rob_ready_i,
    input  logic [XLEN-1:0]      rob_value_i,
    input  logic                 commit_valid_i,
    input  reg_addr_t            commit_dest_i,
    input  logic [ROB_WIDTH-1:0] commit_rob_id_i,
    input  logic [XLEN-1:0]      commit_value_i,
    output logic                 rd_dirty_o,
    output logic [ROB_WIDTH-1:0] rd_dep_o,
    output logic [XLEN-1:0]      rd_value_o,
    output logic [ROB_WIDTH-1:0] rob_dep_o
);

    reg_addr_t            addr_q;
    reg_addr_t            addr_d;
    logic                 sel_busy;
    logic [ROB_WIDTH-1:0] sel_tag;
    logic [XLEN-1:0]      sel_reg;
    logic                 commit_fwd;

    assign addr_d = addr_i;

    // Capture the read address; results are produced from it next cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q <= REG_ZERO;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Operand resolution: x0 mask, then commit forwarding, then ROB/register.
    always_comb begin
        sel_busy   = busy_i[addr_q];
        sel_tag    = tag_i[addr_q];
        sel_reg    = reg_i[addr_q];
        // The committing instruction is exactly the pending producer.
        commit_fwd = commit_valid_i && (commit_dest_i == addr_q) &&
                     sel_busy && (sel_tag == commit_rob_id_i);

        rob_dep_o  = sel_tag;
        rd_dep_o   = sel_tag;
        rd_dirty_o = 1'b0;
        rd_value_o = '0;

        if (is_zero_reg(addr_q)) begin
            rd_dep_o   = '0;
            rd_dirty_o = 1'b0;
            rd_value_o = '0;
        end else if (commit_fwd) begin
            rd_dirty_o = 1'b0;
            rd_value_o = commit_value_i;
        end else if (sel_busy) begin
            rd_dirty_o = ~rob_ready_i;
            rd_value_o = rob_value_i;
        end else begin
            rd_dirty_o = 1'b0;
            rd_value_o = sel_reg;
        end
    end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags. Holds the
// committed values, a busy bit per register and the ROB id of the youngest
// in-flight producer. Renames, commits and flushes are applied on the rising
// edge; operand reads are served by NUM_READ rf_read_port instances.
module rename_register_file
    import rf_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int XLEN      = 32,
    parameter int NUM_READ  = 2
) (
    input  logic                   clockIn,
    input  logic                   resetIn,
    rename_register_file_if.slave  bus
);

    logic [XLEN-1:0]          reg_q  [NUM_ARCH_REGS];
    logic [XLEN-1:0]          reg_d  [NUM_ARCH_REGS];
    logic [ROB_WIDTH-1:0]     tag_q  [NUM_ARCH_REGS];
    logic [ROB_WIDTH-1:0]     tag_d  [NUM_ARCH_REGS];
    logic [NUM_ARCH_REGS-1:0] busy_q;
    logic [NUM_ARCH_REGS-1:0] busy_d;

    logic rename_en;
    logic commit_en;

    logic [NUM_READ-1:0]           rd_dirty;
    logic [NUM_READ*ROB_WIDTH-1:0] rd_dep;
    logic [NUM_READ*XLEN-1:0]      rd_value;
    logic [NUM_READ*ROB_WIDTH-1:0] rob_dep;

    // A flush squashes the rename presented in the same cycle; x0 is never renamed.
    assign rename_en = bus.renameValidIn && !is_zero_reg(bus.renameDestIn) && !bus.flushIn;
    // Commit value writes are unaffected by flush or rename.
    assign commit_en = bus.commitValidIn && !is_zero_reg(bus.commitDestIn);

    // Next-state: commit writes value and may clear busy; rename overrides the
    // clear on the same register; flush overrides everything for busy.
    always_comb begin
        reg_d  = reg_q;
        tag_d  = tag_q;
        busy_d = busy_q;

        if (commit_en) begin
            reg_d[bus.commitDestIn] = bus.commitValueIn;
            // Only the youngest producer may retire the pending state.
            if (tag_q[bus.commitDestIn] == bus.commitRobIdIn) begin
                busy_d[bus.commitDestIn] = 1'b0;
            end
        end

        if (rename_en) begin
            tag_d[bus.renameDestIn]  = bus.renameRobIdIn;
            busy_d[bus.renameDestIn] = 1'b1;
        end

        // Tags are left stale on flush; they are ignored while busy is clear.
        if (bus.flushIn) begin
            busy_d = '0;
        end

        reg_d[REG_ZERO]  = '0;
        tag_d[REG_ZERO]  = '0;
        busy_d[REG_ZERO] = 1'b0;
    end

    // Architectural state registers.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            reg_q  <= '{default: '0};
            tag_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            reg_q  <= reg_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        rf_read_port #(
            .ROB_WIDTH (ROB_WIDTH),
            .XLEN      (XLEN)
        ) u_port (
            .clk_i           (clockIn),
            .rst_n_i         (resetIn),
            .addr_i          (bus.rdAddrIn[k*REG_ADDR_W +: REG_ADDR_W]),
            .busy_i          (busy_q),
            .tag_i           (tag_q),
            .reg_i           (reg_q),
            .rob_ready_i     (bus.robReadyIn[k]),
            .rob_value_i     (bus.robValueIn[k*XLEN +: XLEN]),
            .commit_valid_i  (bus.commitValidIn),
            .commit_dest_i   (bus.commitDestIn),
            .commit_rob_id_i (bus.commitRobIdIn),
            .commit_value_i  (bus.commitValueIn),
            .rd_dirty_o      (rd_dirty[k]),
            .rd_dep_o        (rd_dep[k*ROB_WIDTH +: ROB_WIDTH]),
            .rd_value_o      (rd_value[k*XLEN +: XLEN]),
            .rob_dep_o       (rob_dep[k*ROB_WIDTH +: ROB_WIDTH])
        );
    end

    assign bus.rdDirtyOut = rd_dirty;
    assign bus.rdDepOut   = rd_dep;
    assign bus.rdValueOut = rd_value;
    assign bus.robDepOut  = rob_dep;

endmodule
